// File: rtl/dice_race_game_ctrl_pkg.sv
// Shared types and constants for the dice race game controller.
// Optional macro DICE_RACE_BOUNCE_EN (see dice_move_calc) switches overshoot to bounce-back.
package dice_race_pkg;

   typedef enum logic [2:0] {
      INTRO,
      WAIT_ROLL,
      WAIT_ANIM,
      WIN,
      END
   } game_state_e;

   localparam int TILE_W = 4;
   localparam int DICE_W = 3;

   localparam logic [DICE_W-1:0] DICE_MIN = 3'd1;
   localparam logic [DICE_W-1:0] DICE_MAX = 3'd6;

   localparam logic MENU_START = 1'b0;
   localparam logic MENU_END   = 1'b1;

   function automatic logic dice_legal(input logic [DICE_W-1:0] d);
      return (d >= DICE_MIN) && (d <= DICE_MAX);
   endfunction

endpackage

// File: rtl/dice_race_game_ctrl_if.sv
// Bundle of buttons, dice strobe, renderer handshake and UI-facing game outputs.
// master = upstream/UI environment side, slave = game controller side.
interface dice_race_game_ctrl_if;
   import dice_race_pkg::*;

   logic              btn_up;
   logic              btn_down;
   logic              btn_select;
   logic              dice_valid;
   logic [DICE_W-1:0] dice_value;
   logic              turn_done;

   logic              is_intro_state;
   logic              menu_select;
   logic [TILE_W-1:0] p1_pos;
   logic [TILE_W-1:0] p2_pos;
   logic              pos_valid;
   logic              winner_valid;
   logic              turn;
   logic              winner;
   logic              game_end;

   modport master (
      output btn_up, btn_down, btn_select, dice_valid, dice_value, turn_done,
      input  is_intro_state, menu_select, p1_pos, p2_pos, pos_valid,
             winner_valid, turn, winner, game_end
   );

   modport slave (
      input  btn_up, btn_down, btn_select, dice_valid, dice_value, turn_done,
      output is_intro_state, menu_select, p1_pos, p2_pos, pos_valid,
             winner_valid, turn, winner, game_end
   );

endinterface

// File: rtl/dice_race_game_ctrl_move_calc.sv
// Combinational move: (pos, dice) -> (new_pos, reached_finish).
// Default clamps at FINISH_TILE; with DICE_RACE_BOUNCE_EN an overshoot bounces back and only an exact landing wins.
module dice_move_calc
   import dice_race_pkg::*;
#(
   parameter int FINISH_TILE = 15
) (
   input  logic [TILE_W-1:0] pos_i,
   input  logic [DICE_W-1:0] dice_i,
   output logic [TILE_W-1:0] new_pos_o,
   output logic              reached_finish_o
);

`ifdef DICE_RACE_BOUNCE_EN
   localparam logic [5:0] FIN6 = 6'(FINISH_TILE);

   logic [5:0] sum6;

   assign sum6 = {2'b00, pos_i} + {3'b000, dice_i};

   always_comb begin
      new_pos_o        = sum6[TILE_W-1:0];
      reached_finish_o = (sum6 == FIN6);
      if (sum6 > FIN6) begin
         new_pos_o = TILE_W'((FIN6 << 1) - sum6);
      end
   end
`else
   localparam logic [4:0] FIN5 = 5'(FINISH_TILE);

   logic [4:0] sum5;

   assign sum5 = {1'b0, pos_i} + {2'b00, dice_i};

   always_comb begin
      reached_finish_o = (sum5 >= FIN5);
      new_pos_o        = reached_finish_o ? FIN5[TILE_W-1:0] : sum5[TILE_W-1:0];
   end
`endif

endmodule

// File: rtl/dice_race_game_ctrl.sv
// Game-state controller for the two-player dice race: intro menu, rolls, move animation wait, win and end.
// Move rule variant selected by DICE_RACE_BOUNCE_EN inside dice_move_calc.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// INTRO     | menu shown, up/down pick START/END, select confirms
// WAIT_ROLL | waiting for a legal dice value for the active player
// WAIT_ANIM | position committed, waiting for turn_done or the timeout
// WIN       | winner shown, select returns to the menu
// END       | END GAME confirmed, only reset leaves
module dice_race_game_ctrl
   import dice_race_pkg::*;
#(
   parameter int FINISH_TILE  = 15,
   parameter int ANIM_TIMEOUT = 50_000_000,
   parameter int CNT_W        = 26
) (
   input  logic                  clk,
   input  logic                  reset,
   dice_race_game_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((ANIM_TIMEOUT == 0) ? 0 : ANIM_TIMEOUT - 1);

   game_state_e       state_q;
   logic              is_intro_q;
   logic              menu_q;
   logic [TILE_W-1:0] p1_q;
   logic [TILE_W-1:0] p2_q;
   logic              pos_valid_q;
   logic              winner_valid_q;
   logic              turn_q;
   logic              winner_q;
   logic              game_end_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              won_q;

   logic [TILE_W-1:0] act_pos;
   logic [TILE_W-1:0] move_pos_d;
   logic              reached_d;
   logic              timeout_hit;
   logic              anim_exit;

   assign act_pos     = turn_q ? p2_q : p1_q;
   assign timeout_hit = (ANIM_TIMEOUT != 0) && (cnt_q == TO_LAST);
   // turn_done arriving alongside pos_valid belongs to a previous animation
   assign anim_exit   = (bus.turn_done && !pos_valid_q) || timeout_hit;

   dice_move_calc #(
      .FINISH_TILE (FINISH_TILE)
   ) u_move_calc (
      .pos_i            (act_pos),
      .dice_i           (bus.dice_value),
      .new_pos_o        (move_pos_d),
      .reached_finish_o (reached_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= INTRO;
         is_intro_q     <= 1'b1;
         menu_q         <= MENU_START;
         p1_q           <= '0;
         p2_q           <= '0;
         pos_valid_q    <= 1'b0;
         winner_valid_q <= 1'b0;
         turn_q         <= 1'b0;
         winner_q       <= 1'b0;
         game_end_q     <= 1'b0;
         cnt_q          <= '0;
         won_q          <= 1'b0;
      end else begin
         pos_valid_q <= 1'b0;
         unique case (state_q)
            INTRO: begin
               if (bus.btn_up && !bus.btn_down) begin
                  menu_q <= MENU_START;
               end else if (bus.btn_down && !bus.btn_up) begin
                  menu_q <= MENU_END;
               end
               if (bus.btn_select) begin
                  is_intro_q <= 1'b0;
                  if (menu_q == MENU_START) begin
                     state_q <= WAIT_ROLL;
                     p1_q    <= '0;
                     p2_q    <= '0;
                     turn_q  <= 1'b0;
                  end else begin
                     state_q    <= END;
                     game_end_q <= 1'b1;
                  end
               end
            end
            WAIT_ROLL: begin
               if (bus.dice_valid && dice_legal(bus.dice_value)) begin
                  if (turn_q) begin
                     p2_q <= move_pos_d;
                  end else begin
                     p1_q <= move_pos_d;
                  end
                  won_q       <= reached_d;
                  pos_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= WAIT_ANIM;
               end
            end
            WAIT_ANIM: begin
               if (anim_exit) begin
                  cnt_q <= '0;
                  if (won_q) begin
                     state_q        <= WIN;
                     winner_q       <= turn_q;
                     winner_valid_q <= 1'b1;
                  end else begin
                     state_q <= WAIT_ROLL;
                     turn_q  <= ~turn_q;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WIN: begin
               if (bus.btn_select) begin
                  state_q        <= INTRO;
                  is_intro_q     <= 1'b1;
                  menu_q         <= MENU_START;
                  p1_q           <= '0;
                  p2_q           <= '0;
                  turn_q         <= 1'b0;
                  winner_q       <= 1'b0;
                  winner_valid_q <= 1'b0;
                  won_q          <= 1'b0;
               end
            end
            END: begin
               game_end_q <= 1'b1;
               is_intro_q <= 1'b0;
            end
            default: state_q <= INTRO;
         endcase
      end
   end

   assign bus.is_intro_state = is_intro_q;
   assign bus.menu_select    = menu_q;
   assign bus.p1_pos         = p1_q;
   assign bus.p2_pos         = p2_q;
   assign bus.pos_valid      = pos_valid_q;
   assign bus.winner_valid   = winner_valid_q;
   assign bus.turn           = turn_q;
   assign bus.winner         = winner_q;
   assign bus.game_end       = game_end_q;

endmodule
